// File: rtl/datapath_unit.sv
// rtl/datapath_unit.sv - parametrised register-file/ALU datapath driven by an external control unit
// Optional feature macro: CARRY_FLAG_EN (registered carry and negative flags)
module datapath_unit #(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 4,
  parameter int NUM_REGS  = 4,
  parameter int RSEL      = $clog2(NUM_REGS),
  parameter int B1SEL     = $clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] mem_word,
  input  logic                 reg_wr_en,
  input  logic [RSEL-1:0]      reg_wr_sel,
  input  logic [B1SEL-1:0]     bus1_sel,
  input  logic [1:0]           bus2_sel,
  input  logic                 load_y,
  input  logic                 load_ir,
  input  logic                 load_addr,
  input  logic                 load_pc,
  input  logic                 inc_pc,
  input  logic                 load_flags,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] bus_1,
  output logic                 zero_flag,
  output logic                 carry_flag,
  output logic                 neg_flag
);

  localparam int W = WORD_SIZE;

  localparam logic [B1SEL-1:0]   PC_SEL = B1SEL'(NUM_REGS);
  localparam logic [RSEL:0]      REG_LIMIT = (RSEL + 1)'(NUM_REGS);
  localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_NOT = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_XOR = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] OP_SHL = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] OP_SHR = OP_SIZE'(8);

  logic [W-1:0] r_q [NUM_REGS];
  logic [W-1:0] r_d [NUM_REGS];
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] addr_q, addr_d;
  logic         z_q, z_d;

  logic [W-1:0]       bus_2;
  logic [W-1:0]       alu_out;
  logic [W-1:0]       immediate;
  logic [OP_SIZE-1:0] opcode;
  logic               alu_zero;
  logic               wr_ok;

  assign opcode      = ir_q[W-1:W-OP_SIZE];
  assign immediate   = {{OP_SIZE{1'b0}}, ir_q[W-OP_SIZE-1:0]};
  assign alu_zero    = (alu_out == '0);
  assign wr_ok       = ({1'b0, reg_wr_sel} < REG_LIMIT);
  assign instruction = ir_q;
  assign address     = addr_q;
  assign zero_flag   = z_q;

  // Selects past the PC slot read as zero rather than aliasing a register.
  always_comb begin
    bus_1 = '0;
    if (bus1_sel < PC_SEL) begin
      bus_1 = r_q[bus1_sel[RSEL-1:0]];
    end else if (bus1_sel == PC_SEL) begin
      bus_1 = pc_q;
    end
  end

  always_comb begin
    bus_2 = alu_out;
    case (bus2_sel)
      2'd1:    bus_2 = bus_1;
      2'd2:    bus_2 = mem_word;
      2'd3:    bus_2 = immediate;
      default: bus_2 = alu_out;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (opcode)
      OP_ADD:  alu_out = y_q + bus_1;
      OP_SUB:  alu_out = bus_1 - y_q;
      OP_AND:  alu_out = y_q & bus_1;
      OP_NOT:  alu_out = ~bus_1;
      OP_OR:   alu_out = y_q | bus_1;
      OP_XOR:  alu_out = y_q ^ bus_1;
      OP_SHL:  alu_out = {bus_1[W-2:0], 1'b0};
      OP_SHR:  alu_out = {1'b0, bus_1[W-1:1]};
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    r_d = r_q;
    if (reg_wr_en && wr_ok) begin
      r_d[reg_wr_sel] = bus_2;
    end
    y_d    = load_y    ? bus_2 : y_q;
    ir_d   = load_ir   ? bus_2 : ir_q;
    addr_d = load_addr ? bus_2 : addr_q;
    z_d    = load_flags ? alu_zero : z_q;
    pc_d   = pc_q;
    if (load_pc) begin
      pc_d = bus_2;
    end else if (inc_pc) begin
      pc_d = pc_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_q[i] <= '0;
      end
      y_q    <= '0;
      pc_q   <= '0;
      ir_q   <= '0;
      addr_q <= '0;
      z_q    <= 1'b0;
    end else begin
      r_q    <= r_d;
      y_q    <= y_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      addr_q <= addr_d;
      z_q    <= z_d;
    end
  end

`ifdef CARRY_FLAG_EN
  logic [W:0] add_ext;
  logic       alu_carry;
  logic       c_q, c_d;
  logic       n_q, n_d;

  assign add_ext = {1'b0, y_q} + {1'b0, bus_1};

  // Carry for SUB is a borrow: set when the subtrahend Y exceeds bus_1.
  always_comb begin
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD:  alu_carry = add_ext[W];
      OP_SUB:  alu_carry = (bus_1 < y_q);
      OP_SHL:  alu_carry = bus_1[W-1];
      OP_SHR:  alu_carry = bus_1[0];
      default: alu_carry = 1'b0;
    endcase
  end

  always_comb begin
    c_d = load_flags ? alu_carry : c_q;
    n_d = load_flags ? alu_out[W-1] : n_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      c_q <= c_d;
      n_q <= n_d;
    end
  end

  assign carry_flag = c_q;
  assign neg_flag   = n_q;
`else
  assign carry_flag = 1'b0;
  assign neg_flag   = 1'b0;
`endif

endmodule
